// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the LIFO stack controller: FSM encoding and
// helpers that derive the stack depth and count width from the depth log.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_HOLD = 2'd2
    } state_t;

    localparam int DEF_RAM_WIDTH     = 8;
    localparam int DEF_RAM_DEPTH_LOG = 8;

    function automatic int stack_depth(input int depth_log);
        return 2 ** depth_log;
    endfunction

    function automatic int count_width(input int depth_log);
        return depth_log + 1;
    endfunction

endpackage

// File: rtl/stack_ctrl_ptr.sv
// Stack pointer: occupancy count, full/empty decode and the RAM addresses
// used by the next push (top of free space) and the next pop (top entry).
module stack_ptr
    import stack_ctrl_pkg::*;
#(
    parameter int RAM_DEPTH_LOG = DEF_RAM_DEPTH_LOG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     dec,
    output logic [RAM_DEPTH_LOG:0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [RAM_DEPTH_LOG-1:0] push_addr,
    output logic [RAM_DEPTH_LOG-1:0] pop_addr
);

    localparam int CW          = count_width(RAM_DEPTH_LOG);
    localparam int STACK_DEPTH = stack_depth(RAM_DEPTH_LOG);

    logic [CW-1:0] count_q;

    // inc and dec are mutually exclusive by construction in the controller
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CW'(1);
        end else if (dec) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count     = count_q;
    assign full      = (count_q == CW'(STACK_DEPTH));
    assign empty     = (count_q == '0);
    assign push_addr = count_q[RAM_DEPTH_LOG-1:0];
    // Modulo subtraction gives the right address even when count == depth
    assign pop_addr  = count_q[RAM_DEPTH_LOG-1:0] - RAM_DEPTH_LOG'(1);

endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller driving a single-port synchronous RAM as a hardware stack,
// with push/pop handshakes, a held pop output register and sticky errors.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_DEPTH_LOG = DEF_RAM_DEPTH_LOG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    input  logic [RAM_WIDTH-1:0]     push_data,
    output logic                     push_ready,
    input  logic                     pop_req,
    output logic                     pop_ack,
    output logic                     out_valid,
    output logic [RAM_WIDTH-1:0]     out_data,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [RAM_DEPTH_LOG:0]   count,
    output logic                     overflow_err,
    output logic                     underflow_err,
    input  logic                     err_clr,
    output logic                     ram_write_req,
    output logic [RAM_DEPTH_LOG-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_data,
    input  logic [RAM_WIDTH-1:0]     ram_q
);

    state_t                   state_q;
    state_t                   state_d;
    logic                     push_acc;
    logic [RAM_DEPTH_LOG-1:0] push_addr;
    logic [RAM_DEPTH_LOG-1:0] pop_addr;
    logic [RAM_DEPTH_LOG-1:0] addr_q;
    logic [RAM_WIDTH-1:0]     wdata_q;
    logic                     ov_set;
    logic                     un_set;

    stack_ptr #(
        .RAM_DEPTH_LOG(RAM_DEPTH_LOG)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (push_acc),
        .dec      (pop_ack),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .push_addr(push_addr),
        .pop_addr (pop_addr)
    );

    // Handshakes are masked during reset so nothing reaches the RAM or count
    always_comb begin
        state_d       = state_q;
        pop_ack       = 1'b0;
        push_ready    = 1'b0;
        if (!rst && state_q == ST_IDLE) begin
            pop_ack    = pop_req && !empty;
            push_ready = !full && !(pop_req && !empty);
        end
        push_acc      = push_valid && push_ready;
        ram_write_req = push_acc;
        ram_addr      = addr_q;
        ram_data      = wdata_q;
        if (pop_ack) begin
            ram_addr = pop_addr;
        end else if (push_acc) begin
            ram_addr = push_addr;
            ram_data = push_data;
        end
        case (state_q)
            ST_IDLE:    if (pop_ack) state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_RD_HOLD;
            ST_RD_HOLD: if (out_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign ov_set = (state_q == ST_IDLE) && push_valid && full;
    assign un_set = (state_q == ST_IDLE) && pop_req && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            out_valid     <= 1'b0;
            out_data      <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= ram_addr;
            wdata_q <= ram_data;
            // ram_q carries the word addressed at the pop_ack edge
            if (state_q == ST_RD_WAIT) begin
                out_data  <= ram_q;
                out_valid <= 1'b1;
            end else if (state_q == ST_RD_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
            if (ov_set)       overflow_err <= 1'b1;
            else if (err_clr) overflow_err <= 1'b0;
            if (un_set)       underflow_err <= 1'b1;
            else if (err_clr) underflow_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (depth 4, 8-bit): directed plan steps then random
// traffic, all checked against a queue-based stack model.
module tb_stack_ctrl;

    localparam int W = 8;
    localparam int L = 2;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         push_valid;
    logic [W-1:0] push_data;
    logic         push_ready;
    logic         pop_req;
    logic         pop_ack;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         full;
    logic         empty;
    logic [L:0]   count;
    logic         overflow_err;
    logic         underflow_err;
    logic         err_clr;
    logic         ram_write_req;
    logic [L-1:0] ram_addr;
    logic [W-1:0] ram_data;
    logic [W-1:0] ram_q;

    always #5 clk = ~clk;

    stack_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH_LOG(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .pop_req      (pop_req),
        .pop_ack      (pop_ack),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err),
        .err_clr      (err_clr),
        .ram_write_req(ram_write_req),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    // Simple single-port synchronous RAM, read-before-write
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_req) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference model: a queue holds the stack; phase 0 = accepting,
    // 1 = read in flight, 2 = popped word presented to client
    logic [W-1:0] stk[$];
    int           phase;
    logic [W-1:0] pending;
    logic         m_out_valid;
    logic [W-1:0] m_out_data;
    logic         m_ov;
    logic         m_un;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic pv, input logic [W-1:0] pd, input logic pr,
                       input logic ordy, input logic ec, input logic r);
        logic e_ack, e_rdy, e_wr;
        int   sz;
        push_valid = pv; push_data = pd; pop_req = pr;
        out_ready = ordy; err_clr = ec; rst = r;
        #2;
        sz    = stk.size();
        e_ack = !r && phase == 0 && pr && sz > 0;
        e_rdy = !r && phase == 0 && sz < DEPTH && !(pr && sz > 0);
        e_wr  = pv && e_rdy;
        chk("pop_ack", 32'(pop_ack), 32'(e_ack));
        chk("push_ready", 32'(push_ready), 32'(e_rdy));
        chk("ram_write_req", 32'(ram_write_req), 32'(e_wr));
        if (e_wr) chk("ram_data", 32'(ram_data), 32'(pd));
        @(posedge clk);
        #1;
        if (r) begin
            stk.delete();
            phase = 0; m_out_valid = 0; m_out_data = '0; m_ov = 0; m_un = 0;
        end else begin
            if (phase == 0 && pv && sz == DEPTH) m_ov = 1'b1;
            else if (ec) m_ov = 1'b0;
            if (phase == 0 && pr && sz == 0) m_un = 1'b1;
            else if (ec) m_un = 1'b0;
            if (e_ack) begin
                pending = stk.pop_back();
                phase = 1;
            end else if (e_wr) begin
                stk.push_back(pd);
            end else if (phase == 1) begin
                m_out_valid = 1'b1;
                m_out_data = pending;
                phase = 2;
            end else if (phase == 2 && ordy) begin
                m_out_valid = 1'b0;
                phase = 0;
            end
        end
        chk("count", 32'(count), 32'(stk.size()));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("full", 32'(full), 32'(stk.size() == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(m_out_valid));
        chk("out_data", 32'(out_data), 32'(m_out_data));
        chk("overflow_err", 32'(overflow_err), 32'(m_ov));
        chk("underflow_err", 32'(underflow_err), 32'(m_un));
    endtask

    task automatic idle_n(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        phase = 0; m_out_valid = 0; m_out_data = '0; m_ov = 0; m_un = 0; pending = '0;
        #1;
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Three pushes, three pops: LIFO order, 2-cycle latency
        cyc(1, 8'h11, 0, 1, 0, 0);
        cyc(1, 8'h22, 0, 1, 0, 0);
        cyc(1, 8'h33, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 1, 0, 0);
            idle_n(2, 1'b1);
        end
        chk("lifo_last_word", 32'(out_data), 32'h11);
        chk("empty_after_pops", 32'(empty), 32'd1);

        // Fill, overflow attempt, error clear
        for (int k = 0; k < 4; k++) cyc(1, 8'hA0 + 8'(k), 0, 1, 0, 0);
        chk("full_at_depth", 32'(full), 32'd1);
        cyc(1, 8'hEE, 0, 1, 0, 0);
        chk("overflow_set", 32'(overflow_err), 32'd1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("overflow_clr", 32'(overflow_err), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 1, 0, 0);
            idle_n(2, 1'b1);
        end
        chk("top_not_overwritten", 32'(out_data), 32'hA0);

        // Underflow
        cyc(0, 0, 1, 1, 0, 0);
        chk("underflow_set", 32'(underflow_err), 32'd1);
        cyc(0, 0, 0, 1, 1, 0);

        // Simultaneous push and pop with count=2, then held output
        cyc(1, 8'h01, 0, 1, 0, 0);
        cyc(1, 8'hAB, 0, 1, 0, 0);
        cyc(1, 8'h55, 1, 0, 0, 0);
        idle_n(2, 1'b0);
        chk("pop_top_ab", 32'(out_data), 32'hAB);
        idle_n(5, 1'b0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 8'h55, 0, 1, 0, 0);
        chk("late_push_count", 32'(count), 32'd2);

        // Reset during the read wait
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        cyc(1, 8'h77, 0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom % 2), 8'($urandom), 1'($urandom % 3 == 0),
                1'($urandom % 2), 1'($urandom % 8 == 0), 1'($urandom % 97 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- LIFO controller that sequences one single-port synchronous RAM (write_req/addr/data in, q out, one access per cycle) as a hardware stack.
- Accepts pushes and pops from one client through valid/ready handshakes, and keeps the stack pointer, full/empty and count.
- Issues RAM reads and returns popped data through a held output register.
- Sits between the client logic and the RAM instance; the top level wires the ram_* ports straight to the RAM.

Parameters:
- RAM_WIDTH, 8, data word width in bits.
- RAM_DEPTH_LOG, 8, log2 of stack depth; depth = 2**RAM_DEPTH_LOG entries.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- push_valid  input  1  client offers push_data.
- push_data  input  RAM_WIDTH  word to push.
- push_ready  output  1  controller can accept a push this cycle.
- pop_req  input  1  client requests a pop.
- pop_ack  output  1  pop accepted this cycle.
- out_valid  output  1  out_data holds a popped word.
- out_data  output  RAM_WIDTH  popped word.
- out_ready  input  1  client consumes out_data.
- full  output  1  count == 2**RAM_DEPTH_LOG.
- empty  output  1  count == 0.
- count  output  RAM_DEPTH_LOG+1  number of stored words.
- overflow_err  output  1  sticky: push_valid seen while full.
- underflow_err  output  1  sticky: pop_req seen while empty, in IDLE.
- err_clr  input  1  clears both sticky error flags.
- ram_write_req  output  1  to RAM write_req.
- ram_addr  output  RAM_DEPTH_LOG  to RAM addr.
- ram_data  output  RAM_WIDTH  to RAM data.
- ram_q  input  RAM_WIDTH  from RAM q; valid one cycle after the address is presented.

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided.
- Reset values: state=IDLE, count=0, empty=1, full=0, out_valid=0, out_data=0, errors=0, ram_write_req=0, ram_addr=0, ram_data=0.
- Reset mid-operation drops any in-flight read and clears out_valid. RAM contents are not cleared.
- FSM states are IDLE, RD_WAIT and RD_HOLD.
- IDLE, pop has priority:
  - pop_ack = pop_req && !empty.
  - On pop_ack: ram_addr = count-1, ram_write_req=0, count decrements, next state RD_WAIT.
- IDLE, push:
  - push_ready = (state==IDLE) && !full && !(pop_req && !empty).
  - On push_valid && push_ready: ram_write_req=1, ram_addr = count[RAM_DEPTH_LOG-1:0], ram_data = push_data, count increments the same edge. State stays IDLE, so back-to-back pushes run one per cycle.
- RD_WAIT: capture ram_q into out_data, set out_valid=1, go to RD_HOLD. Pop latency is 2 cycles from pop_ack to out_valid.
- RD_HOLD:
  - out_data is held stable while out_valid=1.
  - On out_ready: clear out_valid, go to IDLE.
  - No push or pop is accepted in RD_WAIT or RD_HOLD.
- ram_* outputs are combinational from state and handshakes. ram_write_req=0 in every state except a push accept.
- When ram_write_req=0 and no pop is accepted, ram_addr holds the previous value. The RAM is always enabled; idle reads are harmless.
- full/empty are decoded from the registered count. Count never wraps: a push at full and a pop at empty are refused.
- Error flags:
  - overflow_err sets when push_valid && full in IDLE.
  - underflow_err sets when pop_req && empty in IDLE.
  - The push-while-pop case is only back-pressure, not an error.
  - err_clr clears both flags; set wins if it coincides with err_clr.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_RD_WAIT, ST_RD_HOLD).
  - Derived constant STACK_DEPTH = 2**RAM_DEPTH_LOG.
  - Count width RAM_DEPTH_LOG+1.
- One natural sub-module, stack_ptr: count register, inc/dec, full/empty decode and next-address generation.
- FSM, output register and error flags stay in stack_ctrl.
- The bench instantiates the team's simple single-port RAM model on the ram_* ports.

Test Plan (RAM_DEPTH_LOG=2, RAM_WIDTH=8):
- Push 0x11,0x22,0x33 on consecutive cycles, then three pops with out_ready=1 -> out_data 0x33,0x22,0x11. Each appears 2 cycles after its pop_ack; count ends at 0 and empty=1.
- Push 4 words -> full=1, push_ready=0, count=4. A further push_valid -> overflow_err=1 and the RAM is not written. err_clr -> overflow_err=0.
- pop_req while empty -> pop_ack=0, underflow_err=1, state stays IDLE, out_valid stays 0.
- push_valid and pop_req in the same cycle with count=2, top=0xAB -> pop_ack=1, push_ready=0, out_data=0xAB, count=1. The push is accepted later in IDLE.
- Hold out_ready=0 for 5 cycles after out_valid -> out_data is stable and push_ready=0. Release -> return to IDLE next cycle.
- Assert rst during RD_WAIT -> next cycle out_valid=0, count=0, empty=1, state IDLE.
